// File: rtl/cpu_clk_pkg.sv
// Shared state type and speed-code decode for the Z80 clock-enable / single-step controller.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    STEP_CLK,
    STEP_INSTR
  } step_state_t;

  localparam logic [2:0] SPEED_DEFAULT = 3'b001;

  // D is 5 bits wide because the slowest code (111) divides by 16.
  function automatic logic [4:0] div_of(input logic [2:0] code);
    logic [2:0] eff;
    eff = (code == 3'b000) ? SPEED_DEFAULT : code;
    return ({2'b00, eff} + 5'd1) << 1;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running period counter; flags the last cycle of each CPU clock period.
module ce_divider
  import cpu_clk_pkg::*;
(
  input  logic       CLK_50M,
  input  logic       RESET_N,
  input  logic [2:0] speed,
  output logic       boundary
);

  logic [3:0] cnt;
  logic [4:0] div;

  assign boundary = ({1'b0, cnt} == (div - 5'd1));

  // The new divide ratio is only taken at a boundary, so no period is ever cut short.
  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
      div <= div_of(SPEED_DEFAULT);
    end else if (boundary) begin
      cnt <= '0;
      div <= div_of(speed);
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/cpu_clk_step_ctrl.sv
// CPU clock-enable generator with run / halt / single-clock / single-instruction stepping.
module cpu_clk_step_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int TIMEOUT_W = 16
) (
  input  logic        CLK_50M,
  input  logic        RESET_N,
  input  logic [2:0]  speed,
  input  logic        step_mode,
  input  logic        step_btn,
  input  logic        step_unit,
  input  logic        m1_n,
  output logic        cpu_ce,
  output logic        halted,
  output logic        busy,
  output logic        timeout,
  output logic [15:0] step_count
);

  localparam logic [TIMEOUT_W:0] WD_LIMIT = {1'b1, {TIMEOUT_W{1'b0}}};
  localparam logic [TIMEOUT_W:0] WD_MIN   = (TIMEOUT_W + 1)'(2);

  step_state_t        state, state_next;
  logic               boundary;
  logic               btn_prev, btn_rise;
  logic               pending, pending_next;
  logic               ce_next, ce_d1, ce_d2;
  logic               m1_prev, m1_cur;
  logic               timeout_next, count_inc, step_start;
  logic [TIMEOUT_W:0] wd;

  ce_divider u_ce_divider (
    .CLK_50M  (CLK_50M),
    .RESET_N  (RESET_N),
    .speed    (speed),
    .boundary (boundary)
  );

  assign btn_rise = step_btn & ~btn_prev;
  assign halted   = (state == HALT);
  assign busy     = (state == STEP_CLK) || (state == STEP_INSTR);

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) state <= RUN;
    else          state <= state_next;
  end

  // The boundary that accepts a step also issues its first ce, keeping press-to-ce within D+2.
  always_comb begin
    state_next   = state;
    ce_next      = 1'b0;
    pending_next = pending;
    timeout_next = timeout;
    count_inc    = 1'b0;
    step_start   = 1'b0;
    case (state)
      RUN: begin
        if (boundary) begin
          if (step_mode) state_next = HALT;
          else           ce_next    = 1'b1;
        end
      end
      HALT: begin
        if (btn_rise && !pending) pending_next = 1'b1;
        if (boundary) begin
          if (!step_mode) begin
            state_next   = RUN;
            pending_next = 1'b0;
          end else if (pending) begin
            pending_next = 1'b0;
            timeout_next = 1'b0;
            ce_next      = 1'b1;
            step_start   = 1'b1;
            state_next   = step_unit ? STEP_INSTR : STEP_CLK;
          end
        end
      end
      STEP_CLK: begin
        count_inc  = 1'b1;
        state_next = HALT;
      end
      STEP_INSTR: begin
        if (boundary) ce_next = 1'b1;
        // ce_d2 marks the cycle after an m1_n sample; D>=4 keeps it ahead of the next boundary.
        if (ce_d2) begin
          if (wd >= WD_MIN && m1_prev && !m1_cur) begin
            count_inc  = 1'b1;
            state_next = HALT;
          end else if (wd == WD_LIMIT) begin
            timeout_next = 1'b1;
            state_next   = HALT;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      cpu_ce     <= 1'b0;
      ce_d1      <= 1'b0;
      ce_d2      <= 1'b0;
      btn_prev   <= 1'b1;
      pending    <= 1'b0;
      timeout    <= 1'b0;
      step_count <= '0;
      m1_prev    <= 1'b1;
      m1_cur     <= 1'b1;
      wd         <= '0;
    end else begin
      cpu_ce   <= ce_next;
      ce_d1    <= cpu_ce;
      ce_d2    <= ce_d1;
      btn_prev <= step_btn;
      pending  <= pending_next;
      timeout  <= timeout_next;
      if (count_inc) step_count <= step_count + 16'd1;
      // m1_n settles one cycle after the ce that clocked the CPU.
      if (ce_d1) begin
        m1_prev <= m1_cur;
        m1_cur  <= m1_n;
      end
      if (step_start)                         wd <= '0;
      else if (state == STEP_INSTR && ce_d1)  wd <= wd + 1'b1;
    end
  end

endmodule
